// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: CPU (port 0) priority with a bounded wait for port 1,
// access legality screening, and registered one-cycle responses.
module dmem_arbiter #(
  parameter int MAX_WAIT   = 4,
  parameter int ADDR_LIMIT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  mw0,
  input  logic [1:0]  mw1,
  input  logic [2:0]  sl0,
  input  logic [2:0]  sl1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] conflicts,
  output logic [1:0]  MemWrite,
  output logic [2:0]  SizeLoad,
  output logic [31:0] a,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

  localparam logic [3:0]  MAX_WAIT_W   = 4'(MAX_WAIT);
  localparam logic [31:0] ADDR_LIMIT_W = 32'(ADDR_LIMIT);

  logic [3:0]  wait_cnt_reg;
  logic [15:0] conflicts_reg;
  logic [1:0]  gnt_vec;
  logic        both_req;
  logic        granted;
  logic        is_load;
  logic        illegal;
  logic [1:0]  sel_mw;
  logic [2:0]  sel_sl;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] load_data;
  logic        rvalid_reg [2];
  logic [31:0] rdata_reg  [2];
  logic        err_reg    [2];

  assign both_req = req0 && req1;

  // Port 1 wins a conflict only once it has lost MAX_WAIT conflicts in a row.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (both_req) begin
        if (wait_cnt_reg >= MAX_WAIT_W) gnt1 = 1'b1;
        else                            gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_vec   = {gnt1, gnt0};
  assign granted   = gnt0 || gnt1;
  assign sel_mw    = gnt1 ? mw1    : mw0;
  assign sel_sl    = gnt1 ? sl1    : sl0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign is_load   = (sel_mw == 2'b00);

  always_comb begin
    illegal = (sel_addr >= ADDR_LIMIT_W);
    case (sel_mw)
      2'b00: begin
        case (sel_sl)
          3'b000:         if (sel_addr[1:0] != 2'b00) illegal = 1'b1;
          3'b001, 3'b101: if (sel_addr[0]) illegal = 1'b1;
          3'b010, 3'b011: ;
          default:        illegal = 1'b1;
        endcase
      end
      2'b01:   if (sel_addr[1:0] != 2'b00) illegal = 1'b1;
      2'b10:   if (sel_addr[0]) illegal = 1'b1;
      default: ;
    endcase
  end

  // Suppressed accesses present a fully idle bus so dmem sees nothing.
  always_comb begin
    MemWrite = 2'b00;
    SizeLoad = 3'b000;
    a        = 32'd0;
    wd       = 32'd0;
    if (granted && !illegal) begin
      MemWrite = sel_mw;
      SizeLoad = is_load ? sel_sl : 3'b000;
      a        = sel_addr;
      wd       = sel_wdata;
    end
  end

  assign load_data = (is_load && !illegal) ? rd : 32'd0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_reg[gi] <= 1'b0;
          rdata_reg[gi]  <= 32'd0;
          err_reg[gi]    <= 1'b0;
        end else begin
          rvalid_reg[gi] <= gnt_vec[gi];
          if (gnt_vec[gi]) begin
            rdata_reg[gi] <= load_data;
            err_reg[gi]   <= illegal;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg  <= 4'd0;
      conflicts_reg <= 16'd0;
    end else begin
      if (both_req && conflicts_reg != 16'hFFFF)
        conflicts_reg <= conflicts_reg + 16'd1;
      if (!both_req || gnt1) wait_cnt_reg <= 4'd0;
      else                   wait_cnt_reg <= wait_cnt_reg + 4'd1;
    end
  end

  assign rvalid0   = rvalid_reg[0];
  assign rvalid1   = rvalid_reg[1];
  assign rdata0    = rdata_reg[0];
  assign rdata1    = rdata_reg[1];
  assign err0      = err_reg[0];
  assign err1      = err_reg[1];
  assign conflicts = conflicts_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array dmem environment, directed scenarios and
// random traffic scored against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT   = 4;
  localparam int ADDR_LIMIT = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic [1:0]  mw    [2];
  logic [2:0]  sl    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1, a, wd, rd;
  logic [15:0] conflicts;
  logic [1:0]  MemWrite;
  logic [2:0]  SizeLoad;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_LIMIT(ADDR_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .req1(req[1]), .mw0(mw[0]), .mw1(mw[1]),
    .sl0(sl[0]), .sl1(sl[1]), .addr0(addr[0]), .addr1(addr[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .conflicts(conflicts), .MemWrite(MemWrite), .SizeLoad(SizeLoad),
    .a(a), .wd(wd), .rd(rd)
  );

  // dmem environment: little-endian bytes, combinational sized read, posedge write
  logic [7:0] mem [256];
  logic       mem_init;
  logic [7:0] ai;
  logic [31:0] mw_word;

  always_comb begin
    ai      = a[7:0];
    mw_word = {mem[ai + 8'd3], mem[ai + 8'd2], mem[ai + 8'd1], mem[ai]};
    case (SizeLoad)
      3'b001:  rd = {{16{mw_word[15]}}, mw_word[15:0]};
      3'b010:  rd = {{24{mw_word[7]}}, mw_word[7:0]};
      3'b011:  rd = {24'd0, mw_word[7:0]};
      3'b101:  rd = {16'd0, mw_word[15:0]};
      default: rd = mw_word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 37 + 91) % 256);
    end else begin
      case (MemWrite)
        2'b01: begin
          mem[ai] <= wd[7:0]; mem[ai + 8'd1] <= wd[15:8];
          mem[ai + 8'd2] <= wd[23:16]; mem[ai + 8'd3] <= wd[31:24];
        end
        2'b10: begin mem[ai] <= wd[7:0]; mem[ai + 8'd1] <= wd[15:8]; end
        2'b11: mem[ai] <= wd[7:0];
        default: ;
      endcase
    end
  end

  // Reference model state
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_lost;
  int          m_conf;
  logic        m_rvalid [2];
  logic [31:0] m_rdata  [2];
  logic        m_err    [2];
  logic [7:0]  ref_mem  [256];
  int          last_gnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int access_size(input logic [1:0] m, input logic [2:0] s);
    if (m == 2'd1) return 4;
    if (m == 2'd2) return 2;
    if (m == 2'd3) return 1;
    case (s)
      3'd0:       return 4;
      3'd1, 3'd5: return 2;
      3'd2, 3'd3: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic [1:0] m, input logic [2:0] s, input logic [31:0] ad);
    int sz;
    if (ad >= 32'(ADDR_LIMIT)) return 1'b0;
    sz = access_size(m, s);
    if (sz == 0) return 1'b0;
    return (ad % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] ad);
    int sz;
    longint v;
    sz = access_size(2'd0, s);
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_mem[ad + i]) << (8 * i);
    if (s == 3'd1 && v >= 32768) v -= 65536;
    if (s == 3'd2 && v >= 128) v -= 256;
    return 32'(v);
  endfunction

  // One clock of traffic: check combinational outputs, advance the model,
  // then check the registered response after the edge.
  task automatic step();
    int g;
    bit lg;
    logic [1:0] e_mw;
    logic [2:0] e_sl;
    logic [31:0] e_a, e_wd;
    #1;
    g = -1;
    if (!reset) begin
      if (req[0] && req[1]) g = (m_lost >= MAX_WAIT) ? 1 : 0;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
    end
    e_mw = 2'd0; e_sl = 3'd0; e_a = 32'd0; e_wd = 32'd0; lg = 1'b0;
    if (g >= 0) begin
      lg = model_legal(mw[g], sl[g], addr[g]);
      if (lg) begin
        e_mw = mw[g];
        e_sl = (mw[g] == 2'd0) ? sl[g] : 3'd0;
        e_a  = addr[g];
        e_wd = wdata[g];
      end
    end
    check_val("gnt0", 32'(gnt0), 32'(g == 0));
    check_val("gnt1", 32'(gnt1), 32'(g == 1));
    check_val("MemWrite", 32'(MemWrite), 32'(e_mw));
    check_val("SizeLoad", 32'(SizeLoad), 32'(e_sl));
    check_val("a", a, e_a);
    check_val("wd", wd, e_wd);
    if (reset) begin
      m_lost = 0; m_conf = 0;
      for (int p = 0; p < 2; p++) begin m_rvalid[p] = 0; m_rdata[p] = 0; m_err[p] = 0; end
    end else begin
      if (req[0] && req[1]) begin
        if (m_conf < 65535) m_conf++;
        m_lost = (g == 1) ? 0 : m_lost + 1;
      end else begin
        m_lost = 0;
      end
      m_rvalid[0] = (g == 0);
      m_rvalid[1] = (g == 1);
      if (g >= 0) begin
        m_err[g]   = !lg;
        m_rdata[g] = (lg && mw[g] == 2'd0) ? model_load(sl[g], addr[g]) : 32'd0;
        if (lg && mw[g] != 2'd0)
          for (int i = 0; i < access_size(mw[g], sl[g]); i++)
            ref_mem[addr[g] + i] = 8'(wdata[g] >> (8 * i));
      end
    end
    last_gnt = g;
    @(posedge clk);
    #1;
    check_val("rvalid0", 32'(rvalid0), 32'(m_rvalid[0]));
    check_val("rvalid1", 32'(rvalid1), 32'(m_rvalid[1]));
    check_val("rdata0", rdata0, m_rdata[0]);
    check_val("rdata1", rdata1, m_rdata[1]);
    check_val("err0", 32'(err0), 32'(m_err[0]));
    check_val("err1", 32'(err1), 32'(m_err[1]));
    check_val("conflicts", 32'(conflicts), 32'(m_conf));
    $display("cycle t=%0t req=%0d%0d gnt=%0d rvalid=%0d%0d err=%0d%0d conflicts=%0d",
             $time, req[0], req[1], g, rvalid0, rvalid1, err0, err1, conflicts);
  endtask

  task automatic set_req(input int p, input logic [1:0] m, input logic [2:0] s,
                         input logic [31:0] ad, input logic [31:0] wdv);
    req[p] = 1'b1; mw[p] = m; sl[p] = s; addr[p] = ad; wdata[p] = wdv;
  endtask

  task automatic new_req(input int p);
    int tbl [5] = '{0, 1, 2, 3, 5};
    int r;
    req[p]   = 1'b1;
    mw[p]    = 2'($urandom_range(0, 3));
    sl[p]    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'(tbl[$urandom_range(0, 4)]);
    r = $urandom_range(0, 7);
    if (r == 0)      addr[p] = $urandom;
    else if (r == 1) addr[p] = 32'(256 + $urandom_range(0, 3));
    else             addr[p] = 32'($urandom_range(0, 255));
    if (r >= 4) addr[p] = addr[p] & ~32'd3;
    wdata[p] = $urandom;
  endtask

  initial begin
    int seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int nbad;
    logic [31:0] word0;
    m_lost = 0; m_conf = 0; last_gnt = -1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; mw[p] = 0; sl[p] = 0; addr[p] = 0; wdata[p] = 0;
      m_rvalid[p] = 0; m_rdata[p] = 0; m_err[p] = 0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 91) % 256);
    word0 = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};

    reset = 1'b1; mem_init = 1'b1;
    step();
    mem_init = 1'b0;

    // Reset holds off everything, including a pending store to word 0
    set_req(0, 2'b01, 3'd0, 32'h0, 32'hCAFEF00D);
    set_req(1, 2'b01, 3'd0, 32'h0, 32'h01234567);
    repeat (3) step();
    check_val("rst_mem_word0", {mem[3], mem[2], mem[1], mem[0]}, word0);
    reset = 1'b0; req[0] = 0; req[1] = 0;

    // Store then sized loads on port 0
    set_req(0, 2'b01, 3'd0, 32'h10, 32'hDEADBEEF); step();
    check_val("sw_gnt", 32'(last_gnt), 32'd0);
    set_req(0, 2'b00, 3'b010, 32'h13, 32'h0); step();
    check_val("lb_rdata", rdata0, 32'hFFFFFFDE);
    set_req(0, 2'b00, 3'b101, 32'h12, 32'h0); step();
    check_val("lhu_rdata", rdata0, 32'h0000DEAD);
    req[0] = 0;

    // Starvation bound under continuous conflict
    reset = 1'b1; step(); reset = 1'b0;
    set_req(0, 2'b00, 3'd0, 32'h0, 32'h0);
    set_req(1, 2'b00, 3'd0, 32'h4, 32'h0);
    for (int c = 0; c < 10; c++) begin
      step();
      check_val($sformatf("starve_seq%0d", c), 32'(last_gnt), 32'(seq[c]));
    end
    check_val("starve_conflicts", 32'(conflicts), 32'd10);
    req[0] = 0; req[1] = 0;

    // Misaligned store is consumed but suppressed
    set_req(1, 2'b01, 3'd0, 32'h2, 32'h11223344); step();
    check_val("mis_err1", 32'(err1), 32'd1);
    check_val("mis_rdata1", rdata1, 32'd0);
    set_req(1, 2'b00, 3'd0, 32'h0, 32'h0); step();
    check_val("mis_word0", rdata1, word0);
    req[1] = 0;

    // Range and encoding errors; byte store at the last address is fine
    set_req(0, 2'b00, 3'd0, 32'h100, 32'h0); step();
    check_val("range_err", 32'(err0), 32'd1);
    set_req(0, 2'b00, 3'b110, 32'h4, 32'h0); step();
    check_val("enc_err", 32'(err0), 32'd1);
    set_req(0, 2'b11, 3'd0, 32'hFF, 32'h000000A5); step();
    check_val("sb_ff_err", 32'(err0), 32'd0);
    set_req(0, 2'b00, 3'b011, 32'hFF, 32'h0); step();
    check_val("lbu_ff", rdata0, 32'h000000A5);
    req[0] = 0;

    // Alternating single requests
    for (int c = 0; c < 8; c++) begin
      req[0] = 0; req[1] = 0;
      set_req(c % 2, 2'b00, 3'd0, 32'(4 * c), 32'h0);
      step();
    end
    req[0] = 0; req[1] = 0;

    // Random traffic obeying the hold-until-grant protocol
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p] && $urandom_range(0, 9) < 6) new_req(p);
      reset = ($urandom_range(0, 63) == 0);
      step();
      if (last_gnt >= 0) req[last_gnt] = 1'b0;
    end
    reset = 1'b0; req[0] = 0; req[1] = 0;
    step();

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check_val("mem_final_bad_bytes", 32'(nbad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the data memory. It shares the single dmem port between the CPU load/store unit (port 0) and a secondary master such as a loader or DMA (port 1). It applies CPU priority with a bounded-wait guarantee for port 1, and checks alignment, range and encoding before any access reaches memory. Responses are registered and returned one cycle after grant.

## Interface
- MAX_WAIT, 4: consecutive conflict cycles port 1 may lose before it is forcibly granted (1..15)
- ADDR_LIMIT, 256: byte size of dmem; addresses >= ADDR_LIMIT are rejected
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; held with its fields stable until the matching gnt
- mw0 / mw1  in  2  store type in dmem encoding: 00 load, 01 sw, 10 sh, 11 sb
- sl0 / sl1  in  3  load type in dmem encoding: 000 LW, 001 LH, 010 LB, 011 LBU, 101 LHU; ignored when mw != 00
- addr0 / addr1  in  32  byte address
- wdata0 / wdata1  in  32  store data, right-aligned
- gnt0 / gnt1  out  1  combinational; access is performed this cycle
- rvalid0 / rvalid1  out  1  registered one-cycle completion pulse, for loads and stores
- rdata0 / rdata1  out  32  registered load data; 0 for stores and errors
- err0 / err1  out  1  registered; qualifies rvalid; access was suppressed
- conflicts  out  16  saturating count of cycles with req0 and req1 both high
- MemWrite  out  2  to dmem
- SizeLoad  out  3  to dmem
- a, wd  out  32  to dmem address and write data
- rd  in  32  from dmem, combinational read data

## Operation
- Arbitration is evaluated each cycle while reset is low:
  - Only req0 high: grant port 0.
  - Only req1 high: grant port 1; wait_cnt <= 0.
  - Both high and wait_cnt < MAX_WAIT: grant port 0; wait_cnt <= wait_cnt + 1; conflicts increments, saturating at 16'hFFFF.
  - Both high and wait_cnt == MAX_WAIT: grant port 1; wait_cnt <= 0; conflicts increments.
  - req1 low: wait_cnt <= 0.
- At most one gnt is high per cycle. gnt never rises without its req.
- A granted request is **illegal** if any of the following holds:
  - addr >= ADDR_LIMIT.
  - Load with sl in {100, 110, 111}.
  - LW or sw with addr[1:0] != 00.
  - LH, LHU or sh with addr[0] = 1.
  - LB, LBU and sb are always aligned.
- Legal grant: the block drives MemWrite = mw, SizeLoad = sl (000 for stores), a = addr and wd = wdata of the granted port. The store commits at this posedge.
- Illegal grant: the block drives MemWrite = 00, so dmem is not modified. The request is still granted and consumed.
- Idle cycles and illegal grants: MemWrite = 00, SizeLoad = 000, a = 0, wd = 0.
- Response registers update on the posedge ending the grant cycle:
  - rvalid of the granted port is set to 1; the other rvalid is set to 0.
  - rdata is set to rd for a legal load, otherwise 0.
  - err is set to 1 for an illegal grant.
  - rdata and err of the non-granted port hold their previous values.

## Timing
- Reset values: rvalid0/1 = 0, rdata0/1 = 0, err0/1 = 0, wait_cnt = 0, conflicts = 0.
- While reset is high: gnt0/1 = 0 and MemWrite = 00.
- Reset mid-operation: a response pending for the next cycle is dropped, and no write reaches dmem in the reset cycle.
- Grant latency: 0 cycles (same cycle as req when it wins arbitration).
- Response latency: rvalid rises exactly 1 cycle after gnt.
- Throughput: one access per cycle across both ports. Back-to-back grants to the same port give back-to-back rvalid pulses.
- Store-then-load to the same address on consecutive cycles returns the new data, because the write commits at the posedge before the load's combinational read.
- Bounded wait: under continuous req0, port 1 is granted within MAX_WAIT+1 cycles of raising req1.

## Test plan
- **Reset:** hold reset 3 cycles with req0 = req1 = 1 and mw0 = 01 -> gnt0/1 = 0, MemWrite = 00, all registered outputs 0, and dmem word 0 unchanged.
- **Store then load on port 0:** port 0 sw 32'hDEADBEEF to 0x10, then LB from 0x13 -> gnt0 both cycles, rvalid0 on cycles 1 and 2, and rdata0 = 32'hFFFFFFDE on the LB response. Then LHU from 0x12 -> rdata0 = 32'h0000DEAD.
- **Starvation bound:** req0 and req1 held high, MAX_WAIT = 4 -> grant sequence 0,0,0,0,1,0,0,0,0,1 and conflicts = 10 after 10 cycles.
- **Misaligned access:** port 1 sw to 0x02 -> gnt1 = 1, MemWrite = 00, next cycle rvalid1 = 1, err1 = 1, rdata1 = 0, and a following LW from 0x00 is unchanged.
- **Range and encoding errors:** LW from 0x100 (ADDR_LIMIT = 256) -> err = 1. Load with sl = 3'b110 at 0x04 -> err = 1. sb to 0xFF -> accepted with err = 0.
- **Back-to-back alternation:** req0 and req1 alternate each cycle -> each is granted in its own cycle, rvalid0/rvalid1 alternate one cycle later, and wait_cnt stays 0.
